phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Parametrised instruction-phase clock generator for the SIMPLE CPU datapath.
//  Emits NUM_PHASES one-cycle phase pulses in order, with GAP_CYCLES idle cycles after each.
//  Supports free-run, instruction-step and phase-step modes, halt-at-boundary and restart
//  from a debounced front-panel exec button. Drives datapath phase enables and panel LEDs.
// PARAMETERS
//  NUM_PHASES       5   number of phase pulses per instruction (2..16)
//  GAP_CYCLES       1   idle cycles after every phase pulse, including the last (0..7)
//  DEBOUNCE_CYCLES  4   consecutive equal samples required to accept a button level
// PORTS
//  clock        in   1             system clock, all logic on posedge
//  reset_n      in   1             asynchronous active-low reset
//  exec_button  in   1             raw, bouncing exec push-button (active high)
//  halt_in      in   1             halt request from datapath (HLT decoded), level
//  step_mode    in   2             00 run, 01 instruction step, 10 phase step, 11 = run
//  phase_pulse  out  NUM_PHASES    one-hot phase pulse; bit k high one cycle for phase k
//  phase_index  out  $clog2(NUM_PHASES)  index of current/most recent phase
//  running      out  1             1 while state = RUN
//  halted       out  1             1 while state = HALTED
//  status_led   out  8             FF run, 81 halted, 18 paused, 00 stopped
// BEHAVIOUR
//  - Reset (async): state STOPPED, phase_pulse 0, phase_index 0, slot 0, halt_req 0,
//    running 0, halted 0, status_led 00. All outputs are registered.
//  - States: STOPPED, RUN, PAUSED (phase step waiting), HALTED.
//  - exec_start: one-cycle pulse on the debounced 0->1 transition. Debounced level
//    changes after DEBOUNCE_CYCLES equal consecutive raw samples. It resets to 0.
//  - STOPPED/PAUSED/HALTED + exec_start -> RUN, and step_mode is latched.
//    From STOPPED or HALTED, restart at phase 0. From PAUSED, continue with the next phase.
//    The first phase pulse appears in the cycle after exec_start.
//  - RUN: slot counter 0..GAP_CYCLES. The pulse for phase_index is asserted when slot = 0.
//    Instruction length = NUM_PHASES*(GAP_CYCLES+1) cycles. Index wraps NUM_PHASES-1 -> 0.
//  - halt_req: sticky, set when halt_in = 1 sampled on any posedge in RUN.
//    It is cleared on entry to HALTED.
//  - Instruction boundary = last gap cycle of phase NUM_PHASES-1 (or its pulse cycle
//    when GAP_CYCLES = 0). At the boundary, in priority order:
//      halt_req -> HALTED; latched mode 01 -> STOPPED; else wrap and continue RUN.
//    When RUN continues, step_mode is re-latched at the boundary.
//  - Phase-step (mode 10): after each pulse plus its gap -> PAUSED.
//    If that phase was the boundary and halt_req = 1, go to HALTED instead.
//  - Halt never truncates an instruction. Phases already started always complete.
//  - exec_start while in RUN is ignored.
//  - halt_in while not in RUN is ignored.
//  - exec_start and halt_in in the same cycle from STOPPED: start wins; halt_in is not
//    sampled, since the state was not RUN.
//  - Reset asserted mid-instruction: outputs drop in the same cycle (async), with no
//    partial pulse. After release, wait in STOPPED for exec_start.
//  - Mode change mid-instruction has no effect until the next latch point.
// STRUCTURE
//  - sequencer_pkg: state enum (STOPPED, RUN, PAUSED, HALTED); mode encodings;
//    LED constants (FF, 81, 18, 00); PHASE_W function.
//  - Sub-module button_debouncer: clock, reset_n, raw in -> debounced level and
//    rise pulse, parametrised by DEBOUNCE_CYCLES.
//  - Top level: FSM, phase/slot counters, halt_req latch, output registers.
// TESTING  (NUM_PHASES=5, GAP_CYCLES=1, DEBOUNCE_CYCLES=4 unless stated)
//  1. Reset, run mode, press exec: pulses 00001,00010,00100,01000,10000 spaced 2 cycles.
//     The pattern repeats every 10 cycles, running=1, status_led=FF.
//  2. halt_in pulsed for 1 cycle at phase 2 of instruction 3: phases 3 and 4 still pulse.
//     Then HALTED, halted=1, LED=81, no further pulses. Next exec restarts at phase 0.
//  3. Raw button toggling 1,0,1,0 each cycle, then held 1 for 4 cycles:
//     exactly one exec_start, no pulse before the debounce completes.
//  4. Instruction step: each exec press gives exactly 5 pulses, then STOPPED, LED=00.
//  5. Phase step: each press gives exactly 1 pulse, then PAUSED, LED=18.
//     The 6th press gives phase 0 again.
//  6. reset_n low during phase 3 gap: all outputs 0 immediately.
//     After release, exec press gives phase 0. Repeat with NUM_PHASES=8, GAP_CYCLES=0:
//     back-to-back pulses, 8-cycle period.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the instruction-phase sequencer:
// FSM states, step-mode encodings, panel LED patterns and a width helper.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_HALTED  = 2'd3
  } seq_state_e;

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_ISTEP   = 2'b01;
  localparam logic [1:0] MODE_PSTEP   = 2'b10;
  localparam logic [1:0] MODE_RUN_ALT = 2'b11;

  localparam logic [7:0] LED_RUN     = 8'hFF;
  localparam logic [7:0] LED_HALTED  = 8'h81;
  localparam logic [7:0] LED_PAUSED  = 8'h18;
  localparam logic [7:0] LED_STOPPED = 8'h00;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int phase_w(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

  function automatic logic [7:0] led_for(input seq_state_e s);
    case (s)
      ST_RUN:     return LED_RUN;
      ST_HALTED:  return LED_HALTED;
      ST_PAUSED:  return LED_PAUSED;
      ST_STOPPED: return LED_STOPPED;
      default:    return LED_STOPPED;
    endcase
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Front-panel / datapath bundle of the phase sequencer. The sequencer is the
// master (drives phase enables and LEDs); panel and datapath are the slave.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 5
) ();
  import phase_sequencer_pkg::*;

  localparam int PW = phase_w(NUM_PHASES);

  logic                  exec_button;
  logic                  halt_in;
  logic [1:0]            step_mode;
  logic [NUM_PHASES-1:0] phase_pulse;
  logic [PW-1:0]         phase_index;
  logic                  running;
  logic                  halted;
  logic [7:0]            status_led;

  modport master (
    input  exec_button, halt_in, step_mode,
    output phase_pulse, phase_index, running, halted, status_led
  );

  modport slave (
    output exec_button, halt_in, step_mode,
    input  phase_pulse, phase_index, running, halted, status_led
  );

endinterface

// File: rtl/phase_sequencer_button.sv
// Exec push-button conditioner: two-flop synchroniser, then a level that only
// changes after DEBOUNCE_CYCLES consecutive equal samples, plus a rise pulse.
module button_debouncer
  import phase_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = phase_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw input and count consecutive samples that disagree with the level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          rise_r  <= sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          rise_r  <= 1'b0;
          cnt_r   <= cnt_r + CW'(1'b1);
        end
      end else begin
        rise_r <= 1'b0;
        cnt_r  <= {CW{1'b0}};
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase clock generator: NUM_PHASES one-cycle pulses each followed
// by GAP_CYCLES idle cycles, with run / instruction-step / phase-step modes.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES      = 5,
  parameter int GAP_CYCLES      = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  phase_sequencer_if.master bus
);

  localparam int PW = phase_w(NUM_PHASES);
  localparam int SW = phase_w(GAP_CYCLES + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_PHASES - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(GAP_CYCLES);
  localparam logic [NUM_PHASES-1:0] ONE_HOT0 = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  seq_state_e            state_r, state_s;
  logic [PW-1:0]         idx_r, idx_s, idx_next_s;
  logic [SW-1:0]         slot_r, slot_s;
  logic [1:0]            mode_r, mode_s;
  logic                  halt_req_r, halt_req_s;
  logic                  exec_level_s, exec_rise_s, exec_start_s;
  logic                  phase_end_s, boundary_s, halt_seen_s;
  logic [NUM_PHASES-1:0] phase_pulse_r;
  logic [PW-1:0]         phase_index_r;
  logic                  running_r, halted_r;
  logic [7:0]            status_led_r;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exec_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (bus.exec_button),
    .level  (exec_level_s),
    .rise   (exec_rise_s)
  );

  assign exec_start_s = exec_rise_s & exec_level_s;
  assign phase_end_s  = (slot_r == LAST_SLOT);
  assign boundary_s   = phase_end_s && (idx_r == LAST_IDX);
  // A halt request seen on the boundary edge itself still stops this instruction.
  assign halt_seen_s  = halt_req_r | bus.halt_in;
  assign idx_next_s   = (idx_r == LAST_IDX) ? {PW{1'b0}} : idx_r + PW'(1'b1);

  // State, counter, mode and halt-request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_STOPPED;
      idx_r      <= {PW{1'b0}};
      slot_r     <= {SW{1'b0}};
      mode_r     <= MODE_RUN;
      halt_req_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      slot_r     <= slot_s;
      mode_r     <= mode_s;
      halt_req_r <= halt_req_s;
    end
  end

  // Next-state logic: phases always run to completion before any stop decision.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    slot_s     = slot_r;
    mode_s     = mode_r;
    halt_req_s = halt_req_r;
    case (state_r)
      ST_RUN: begin
        halt_req_s = halt_seen_s;
        if (!phase_end_s) begin
          slot_s = slot_r + SW'(1'b1);
        end else if (boundary_s) begin
          if (halt_seen_s) begin
            state_s    = ST_HALTED;
            halt_req_s = 1'b0;
          end else if (mode_r == MODE_ISTEP) begin
            state_s = ST_STOPPED;
          end else if (mode_r == MODE_PSTEP) begin
            state_s = ST_PAUSED;
          end else begin
            idx_s  = {PW{1'b0}};
            slot_s = {SW{1'b0}};
            mode_s = bus.step_mode;
          end
        end else if (mode_r == MODE_PSTEP) begin
          state_s = ST_PAUSED;
        end else begin
          idx_s  = idx_next_s;
          slot_s = {SW{1'b0}};
        end
      end
      ST_STOPPED, ST_HALTED: begin
        if (exec_start_s) begin
          state_s = ST_RUN;
          idx_s   = {PW{1'b0}};
          slot_s  = {SW{1'b0}};
          mode_s  = bus.step_mode;
        end else begin
          state_s = state_r;
        end
      end
      ST_PAUSED: begin
        if (exec_start_s) begin
          state_s = ST_RUN;
          idx_s   = idx_next_s;
          slot_s  = {SW{1'b0}};
          mode_s  = bus.step_mode;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s    = ST_STOPPED;
        idx_s      = {PW{1'b0}};
        slot_s     = {SW{1'b0}};
        mode_s     = MODE_RUN;
        halt_req_s = 1'b0;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_pulse_r <= {NUM_PHASES{1'b0}};
      phase_index_r <= {PW{1'b0}};
      running_r     <= 1'b0;
      halted_r      <= 1'b0;
      status_led_r  <= LED_STOPPED;
    end else begin
      if ((state_s == ST_RUN) && (slot_s == {SW{1'b0}})) begin
        phase_pulse_r <= ONE_HOT0 << idx_s;
      end else begin
        phase_pulse_r <= {NUM_PHASES{1'b0}};
      end
      phase_index_r <= idx_s;
      running_r     <= (state_s == ST_RUN);
      halted_r      <= (state_s == ST_HALTED);
      status_led_r  <= led_for(state_s);
    end
  end

  assign bus.phase_pulse = phase_pulse_r;
  assign bus.phase_index = phase_index_r;
  assign bus.running     = running_r;
  assign bus.halted      = halted_r;
  assign bus.status_led  = status_led_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed + randomised bench for phase_sequencer; two instances (5 phases/gap 1
// and 8 phases/gap 0) checked every cycle against an instruction-position model.
module tb_phase_sequencer;

  localparam int S_STOP = 0, S_RUN = 1, S_PAUSE = 2, S_HALT = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       exec_button;
  logic       halt_in;
  logic [1:0] step_mode;

  phase_sequencer_if #(.NUM_PHASES(5)) bus_a ();
  phase_sequencer_if #(.NUM_PHASES(8)) bus_b ();

  assign bus_a.exec_button = exec_button;
  assign bus_a.halt_in     = halt_in;
  assign bus_a.step_mode   = step_mode;
  assign bus_b.exec_button = exec_button;
  assign bus_b.halt_in     = halt_in;
  assign bus_b.step_mode   = step_mode;

  phase_sequencer #(.NUM_PHASES(5), .GAP_CYCLES(1), .DEBOUNCE_CYCLES(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  phase_sequencer #(.NUM_PHASES(8), .GAP_CYCLES(0), .DEBOUNCE_CYCLES(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  int          sel;
  logic [31:0] obs_pulse, obs_idx, obs_run, obs_halt, obs_led;

  always_comb begin
    if (sel == 0) begin
      obs_pulse = {27'd0, bus_a.phase_pulse};
      obs_idx   = {29'd0, bus_a.phase_index};
      obs_run   = {31'd0, bus_a.running};
      obs_halt  = {31'd0, bus_a.halted};
      obs_led   = {24'd0, bus_a.status_led};
    end else begin
      obs_pulse = {24'd0, bus_b.phase_pulse};
      obs_idx   = {29'd0, bus_b.phase_index};
      obs_run   = {31'd0, bus_b.running};
      obs_halt  = {31'd0, bus_b.halted};
      obs_led   = {24'd0, bus_b.status_led};
    end
  end

  int    errors, checks;
  string cur_tag;
  // model: position within the instruction, counted in cycles
  int    cfg_n, cfg_g;
  int    m_state, m_pos, m_mode;
  bit    m_halt, m_level, m_rise;
  bit    rawh [6];
  // statistics for directed checks
  int          pulses_seen, call_cnt, first_call;
  logic [31:0] first_vec;

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_STOP; m_pos = 0; m_mode = 0; m_halt = 1'b0;
    m_level = 1'b0; m_rise = 1'b0;
    for (int i = 0; i < 6; i++) rawh[i] = 1'b0;
  endtask

  task automatic model_edge(input bit raw, input bit halt, input int mode);
    bit start;
    int per, len;
    per = cfg_g + 1;
    len = cfg_n * per;
    start = m_rise;
    for (int i = 5; i > 0; i--) rawh[i] = rawh[i-1];
    rawh[0] = raw;
    // a new level is accepted once four synchronised samples agree
    m_rise = 1'b0;
    if (rawh[2] == rawh[3] && rawh[3] == rawh[4] && rawh[4] == rawh[5] && rawh[2] != m_level) begin
      m_level = rawh[2];
      m_rise  = rawh[2];
    end
    if (m_state == S_RUN) begin
      if (halt) m_halt = 1'b1;
      if (m_pos == len - 1) begin
        if (m_halt) begin m_state = S_HALT; m_halt = 1'b0; end
        else if (m_mode == 1) m_state = S_STOP;
        else if (m_mode == 2) m_state = S_PAUSE;
        else begin m_pos = 0; m_mode = mode; end
      end else if ((m_pos % per) == per - 1 && m_mode == 2) begin
        m_state = S_PAUSE;
      end else begin
        m_pos++;
      end
    end else if (start) begin
      if (m_state == S_PAUSE) m_pos = (((m_pos / per) + 1) % cfg_n) * per;
      else m_pos = 0;
      m_mode  = mode;
      m_state = S_RUN;
    end
  endtask

  task automatic check_outputs();
    int per;
    logic [31:0] ep, el;
    per = cfg_g + 1;
    ep = (m_state == S_RUN && (m_pos % per) == 0) ? (32'd1 << (m_pos / per)) : 32'd0;
    case (m_state)
      S_RUN:   el = 32'hFF;
      S_HALT:  el = 32'h81;
      S_PAUSE: el = 32'h18;
      default: el = 32'h00;
    endcase
    expect_val({cur_tag, "/pulse"},   obs_pulse, ep);
    expect_val({cur_tag, "/index"},   obs_idx,   32'(m_pos / per));
    expect_val({cur_tag, "/running"}, obs_run,   32'(m_state == S_RUN));
    expect_val({cur_tag, "/halted"},  obs_halt,  32'(m_state == S_HALT));
    expect_val({cur_tag, "/led"},     obs_led,   el);
  endtask

  task automatic clear_stats();
    pulses_seen = 0; call_cnt = 0; first_call = 0; first_vec = 32'd0;
  endtask

  // one clock: drive inputs, advance the model at the edge, check on the falling edge
  task automatic cycle(input bit raw, input bit halt, input logic [1:0] mode);
    exec_button = raw; halt_in = halt; step_mode = mode;
    @(posedge clock);
    model_edge(raw, halt, int'(mode));
    @(negedge clock);
    check_outputs();
    call_cnt++;
    if (obs_pulse != 32'd0) begin
      pulses_seen++;
      if (first_call == 0) begin first_call = call_cnt; first_vec = obs_pulse; end
    end
  endtask

  task automatic run(input int n, input logic [1:0] mode, input int halt_pct);
    for (int i = 0; i < n; i++) cycle(1'b0, ($urandom_range(0, 99) < halt_pct), mode);
  endtask

  task automatic press(input int bounces, input int hold, input logic [1:0] mode);
    for (int i = 0; i < bounces; i++) cycle((i % 2) == 0, 1'b0, mode);
    for (int i = 0; i < hold; i++) cycle(1'b1, 1'b0, mode);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, mode);
  endtask

  task automatic wait_pos(input int target, input logic [1:0] mode);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_state == S_RUN && m_pos == target) found = 1'b1;
      else cycle(1'b0, 1'b0, mode);
    end
    checks++;
    if (!found) begin
      errors++;
      $error("FAIL %s/wait_pos: position %0d not reached, at %0d", cur_tag, target, m_pos);
    end
  endtask

  task automatic reset_mid();
    #2 reset_n = 1'b0;
    #1;
    expect_val({cur_tag, "/rst_pulse"},   obs_pulse, 32'd0);
    expect_val({cur_tag, "/rst_index"},   obs_idx,   32'd0);
    expect_val({cur_tag, "/rst_running"}, obs_run,   32'd0);
    expect_val({cur_tag, "/rst_led"},     obs_led,   32'd0);
    model_reset();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; sel = 0; cfg_n = 5; cfg_g = 1;
    reset_n = 1'b0; exec_button = 1'b0; halt_in = 1'b0; step_mode = 2'b00;
    model_reset(); clear_stats();
    cur_tag = "reset";
    #1 check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    run(5, 2'b00, 0);

    cur_tag = "free_run";
    press(2, 5, 2'b00);
    run(30, 2'b00, 0);
    clear_stats();
    run(10, 2'b00, 0);
    expect_val("free_run/pulses_per_10", 32'(pulses_seen), 32'd5);

    cur_tag = "halt";
    wait_pos(2 * (cfg_g + 1), 2'b00);
    clear_stats();
    cycle(1'b0, 1'b1, 2'b00);
    run(25, 2'b00, 0);
    expect_val("halt/pulses_after_halt", 32'(pulses_seen), 32'd2);
    expect_val("halt/halted", obs_halt, 32'd1);
    expect_val("halt/led", obs_led, 32'h81);
    clear_stats();
    press(0, 4, 2'b00);
    expect_val("halt/restart_phase0", first_vec, 32'h1);
    cycle(1'b0, 1'b1, 2'b00);
    run(15, 2'b00, 0);

    cur_tag = "istep";
    for (int i = 0; i < 3; i++) begin
      clear_stats();
      press(0, 4, 2'b01);
      run(10, 2'b01, 0);
      expect_val("istep/pulses", 32'(pulses_seen), 32'd5);
      expect_val("istep/led", obs_led, 32'h00);
    end

    cur_tag = "debounce";
    clear_stats();
    press(4, 4, 2'b10);
    expect_val("debounce/one_start", 32'(pulses_seen), 32'd1);
    expect_val("debounce/first_pulse_cycle", 32'(first_call), 32'd11);

    cur_tag = "pstep";
    for (int i = 1; i <= 5; i++) begin
      clear_stats();
      press(0, 4, 2'b10);
      expect_val("pstep/pulses", 32'(pulses_seen), 32'd1);
      expect_val("pstep/phase", first_vec, 32'd1 << (i % 5));
      expect_val("pstep/led", obs_led, 32'h18);
    end

    cur_tag = "reset_mid";
    press(0, 4, 2'b00);
    wait_pos(3 * (cfg_g + 1) + 1, 2'b00);
    reset_mid();
    clear_stats();
    press(0, 4, 2'b00);
    expect_val("reset_mid/restart_phase0", first_vec, 32'h1);

    cur_tag = "random";
    for (int i = 0; i < 12; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      press($urandom_range(0, 5), $urandom_range(4, 6), m);
      run($urandom_range(5, 25), 2'($urandom_range(0, 3)), 8);
    end

    cur_tag = "cfg8";
    sel = 1; cfg_n = 8; cfg_g = 0;
    reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    press(1, 5, 2'b00);
    clear_stats();
    run(16, 2'b00, 0);
    expect_val("cfg8/back_to_back", 32'(pulses_seen), 32'd16);
    wait_pos(3, 2'b00);
    reset_mid();
    clear_stats();
    press(0, 4, 2'b00);
    expect_val("cfg8/restart_phase0", first_vec, 32'h1);
    run(12, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
